// File: rtl/dmi_wb_pkg.sv
// dmi_wb_pkg: shared encodings for the DMI-to-Wishbone bridge.
//   - DMI request op codes and DMI response status codes
//   - bridge FSM state type
//   - Debug Module register addresses shared with the DM Wishbone slave
package dmi_wb_pkg;

  localparam logic [1:0] DMI_OP_NOP   = 2'd0;
  localparam logic [1:0] DMI_OP_READ  = 2'd1;
  localparam logic [1:0] DMI_OP_WRITE = 2'd2;

  localparam logic [1:0] DMI_RESP_OK     = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } dmi_wb_state_e;

  localparam logic [6:0] DM_ADDR_DATA0     = 7'h04;
  localparam logic [6:0] DM_ADDR_DATA1     = 7'h05;
  localparam logic [6:0] DM_ADDR_DMCONTROL = 7'h10;
  localparam logic [6:0] DM_ADDR_COMMAND   = 7'h17;

endpackage

// File: rtl/dmi_wb_timeout.sv
// dmi_wb_timeout: wait-cycle counter for the bridge's bus states.
//   clk_i      clock
//   rst_i      asynchronous active-low reset
//   clr_i      restart the count at zero on the next edge
//   en_i       count this cycle (bridge is in a waiting state)
//   expired_o  high during the LIMIT-th consecutive enabled cycle
// Only instantiated when DMI_WB_TIMEOUT_EN is defined.
import dmi_wb_pkg::*;

module dmi_wb_timeout #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (en_i) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Flags the cycle in which the count is about to reach LIMIT, so the
  // waiting state lasts exactly LIMIT cycles.
  assign expired_o = en_i && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/dmi_wishbone_master.sv
// dmi_wishbone_master: turns DMI requests into single classic Wishbone
// cycles towards the Debug Module register slave.
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o      DMI request handshake
//   req_addr_i/_data_i/_op_i     DMI request fields (op: 0 nop 1 rd 2 wr)
//   resp_valid_o/resp_ready_i    DMI response handshake
//   resp_data_o/resp_op_o        read data / status (0 ok, 2 failed)
//   addr_o, we_o, data_o         Wishbone master address/control/data
//   cyc_o, stb_o                 Wishbone cycle and strobe
//   data_i, ack_i                Wishbone slave return
// Optional feature macro: DMI_WB_TIMEOUT_EN bounds the ack waits to
// TIMEOUT_CYCLES cycles; without it the bridge waits forever.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | ready for a DMI request
// REQ     | Wishbone cycle active, waiting for ack
// RELEASE | strobe dropped, waiting for the slave to lower ack
// RESP    | DMI response presented, waiting for resp_ready_i
import dmi_wb_pkg::*;

module dmi_wishbone_master #(
  parameter int unsigned ABITS          = 7,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [ABITS-1:0] req_addr_i,
  input  logic [31:0]      req_data_i,
  input  logic [1:0]       req_op_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_data_o,
  output logic [1:0]       resp_op_o,
  output logic [31:0]      addr_o,
  output logic             we_o,
  output logic [63:0]      data_o,
  output logic             cyc_o,
  output logic             stb_o,
  input  logic [63:0]      data_i,
  input  logic             ack_i
);

  dmi_wb_state_e state;
  logic          accept;
  logic          tmo_expired;

  assign accept = req_valid_i && req_ready_o;

  // The DM registers are 32 bits wide; the upper bus half carries nothing.
  logic unused_data_hi;
  assign unused_data_hi = ^data_i[63:32];

`ifdef DMI_WB_TIMEOUT_EN
  logic tmo_clr;
  logic tmo_en;

  assign tmo_en  = (state == ST_REQ) || (state == ST_RELEASE);
  // Restart on leaving REQ so RELEASE gets its own full budget.
  assign tmo_clr = !tmo_en || ((state == ST_REQ) && (ack_i || tmo_expired));

  dmi_wb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (tmo_clr),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;

  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      req_ready_o  <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= '0;
      resp_op_o    <= DMI_RESP_OK;
      addr_o       <= '0;
      we_o         <= 1'b0;
      data_o       <= '0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (accept) begin
            req_ready_o <= 1'b0;
            case (req_op_i)
              DMI_OP_READ, DMI_OP_WRITE: begin
                state  <= ST_REQ;
                cyc_o  <= 1'b1;
                stb_o  <= 1'b1;
                addr_o <= 32'(req_addr_i);
                we_o   <= (req_op_i == DMI_OP_WRITE);
                data_o <= (req_op_i == DMI_OP_WRITE) ? {32'h0, req_data_i} : 64'h0;
              end
              DMI_OP_NOP: begin
                state        <= ST_RESP;
                resp_valid_o <= 1'b1;
                resp_data_o  <= '0;
                resp_op_o    <= DMI_RESP_OK;
              end
              default: begin
                state        <= ST_RESP;
                resp_valid_o <= 1'b1;
                resp_data_o  <= '0;
                resp_op_o    <= DMI_RESP_FAILED;
              end
            endcase
          end
        end

        ST_REQ: begin
          if (ack_i || tmo_expired) begin
            // A real ack wins over an expiry in the same cycle.
            if (ack_i) begin
              resp_data_o <= we_o ? 32'h0 : data_i[31:0];
              resp_op_o   <= DMI_RESP_OK;
            end else begin
              resp_data_o <= '0;
              resp_op_o   <= DMI_RESP_FAILED;
            end
            state  <= ST_RELEASE;
            cyc_o  <= 1'b0;
            stb_o  <= 1'b0;
            we_o   <= 1'b0;
            addr_o <= '0;
            data_o <= '0;
          end
        end

        ST_RELEASE: begin
          // The DM slave holds ack until it sees the strobe drop.
          if (!ack_i || tmo_expired) begin
            state        <= ST_RESP;
            resp_valid_o <= 1'b1;
          end
        end

        ST_RESP: begin
          if (resp_ready_i) begin
            state        <= ST_IDLE;
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_wishbone_master.sv
module tb_dmi_wishbone_master;
  import dmi_wb_pkg::*;

  localparam int ABITS = 7;
  localparam int TMO   = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [6:0]  req_addr_i = '0;
  logic [31:0] req_data_i = '0;
  logic [1:0]  req_op_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_data_o;
  logic [1:0]  resp_op_o;
  logic [31:0] addr_o;
  logic        we_o;
  logic [63:0] data_o;
  logic        cyc_o;
  logic        stb_o;
  logic [63:0] data_i = '0;
  logic        ack_i = 1'b0;

  dmi_wishbone_master #(
    .ABITS          (ABITS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .req_data_i   (req_data_i),
    .req_op_i     (req_op_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_data_o  (resp_data_o),
    .resp_op_o    (resp_op_o),
    .addr_o       (addr_o),
    .we_o         (we_o),
    .data_o       (data_o),
    .cyc_o        (cyc_o),
    .stb_o        (stb_o),
    .data_i       (data_i),
    .ack_i        (ack_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- Wishbone slave model (DM-style: ack held until stb drops)
  bit          slave_mute = 1'b0;
  int          slave_dly = 0;
  int          slave_rel = 0;
  int          wait_cnt = 0;
  int          rel_cnt = 0;
  int          wb_cycles = 0;
  logic [31:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [63:0] last_wdata = '0;
  logic [31:0] slave_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
  endfunction

  always @(negedge clk_i) begin
    if (!rst_i) begin
      ack_i    = 1'b0;
      wait_cnt = 0;
      rel_cnt  = 0;
    end else if (cyc_o && stb_o && !ack_i) begin
      if (!slave_mute) begin
        if (wait_cnt >= slave_dly) begin
          ack_i      = 1'b1;
          wait_cnt   = 0;
          wb_cycles++;
          last_addr  = addr_o;
          last_we    = we_o;
          last_wdata = data_o;
          if (we_o) slave_mem[addr_o] = data_o[31:0];
          data_i = {$urandom(), slave_mem.exists(addr_o) ? slave_mem[addr_o] : dflt(addr_o)};
        end else begin
          wait_cnt++;
        end
      end
    end else if (ack_i && !stb_o) begin
      if (rel_cnt >= slave_rel) begin
        ack_i   = 1'b0;
        rel_cnt = 0;
        data_i  = {$urandom(), $urandom()};
      end else begin
        rel_cnt++;
      end
    end
  end

  // ---------------- Reference model: DM register contents as seen over DMI
  logic [31:0] model_mem [logic [31:0]];

  function automatic logic [31:0] exp_read(input logic [6:0] a);
    logic [31:0] key;
    key = {25'h0, a};
    return model_mem.exists(key) ? model_mem[key] : dflt(key);
  endfunction

  // One complete DMI transaction with all timing/value checks.
  task automatic txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wd,
                     input int hold, input bit pre_ready, input string tag);
    int          n;
    int          wb0;
    bit          prev_cyc;
    bit          bus;
    int          exp_cyc;
    logic [31:0] ed;
    logic [1:0]  eo;
    bus = (op == 2'd1) || (op == 2'd2);
    ed  = (op == 2'd1) ? exp_read(addr) : 32'h0;
    eo  = (op == 2'd3) ? 2'd2 : 2'd0;
    if (bus && slave_mute) begin
      ed = 32'h0;
      eo = 2'd2;
    end
    exp_cyc = !bus ? 0 : (slave_mute ? TMO : slave_dly + 1);

    chk({tag, ":ready_before"}, 64'(req_ready_o), 64'd1);
    wb0          = wb_cycles;
    req_valid_i  = 1'b1;
    req_op_i     = op;
    req_addr_i   = addr;
    req_data_i   = wd;
    resp_ready_i = pre_ready;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_op_i    = 2'($urandom_range(0, 3));
    req_addr_i  = 7'($urandom());
    req_data_i  = $urandom();

    n = 0;
    prev_cyc = 1'b0;
    while (!resp_valid_o && n < 300) begin
      if (cyc_o) exp_cyc = exp_cyc - 1;
      prev_cyc = cyc_o;
      @(posedge clk_i); #1;
      n++;
    end
    chk({tag, ":resp_valid"}, 64'(resp_valid_o), 64'd1);
    chk({tag, ":cyc_cycles_left"}, 64'(exp_cyc), 64'd0);
    if (!bus) chk({tag, ":resp_latency"}, 64'(n), 64'd0);
    chk({tag, ":cyc_low_before_resp"}, {62'h0, prev_cyc, cyc_o}, 64'd0);
    chk({tag, ":wb_cycle_count"}, 64'(wb_cycles - wb0), 64'(bus && !slave_mute));
    if (bus && !slave_mute) begin
      chk({tag, ":wb_addr"}, 64'(last_addr), {57'h0, addr});
      chk({tag, ":wb_we"}, 64'(last_we), 64'(op == 2'd2));
      chk({tag, ":wb_wdata"}, last_wdata, (op == 2'd2) ? {32'h0, wd} : 64'h0);
    end
    chk({tag, ":resp_data"}, 64'(resp_data_o), 64'(ed));
    chk({tag, ":resp_op"}, 64'(resp_op_o), 64'(eo));
    if (op == 2'd2 && !slave_mute) model_mem[{25'h0, addr}] = wd;

    if (!pre_ready) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk_i); #1;
        chk({tag, ":hold_valid"}, 64'(resp_valid_o), 64'd1);
        chk({tag, ":hold_data"}, 64'(resp_data_o), 64'(ed));
        chk({tag, ":hold_op"}, 64'(resp_op_o), 64'(eo));
        chk({tag, ":hold_not_ready"}, 64'(req_ready_o), 64'd0);
      end
    end
    resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    resp_ready_i = 1'b0;
    chk({tag, ":resp_done"}, 64'(resp_valid_o), 64'd0);
    chk({tag, ":ready_after"}, 64'(req_ready_o), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          hi_cnt;
    int          resp_seen;
    logic [6:0]  addr_tab [5];
    logic [6:0]  ra;
    logic [1:0]  rop;

    addr_tab[0] = DM_ADDR_DATA0;
    addr_tab[1] = DM_ADDR_DATA1;
    addr_tab[2] = DM_ADDR_DMCONTROL;
    addr_tab[3] = DM_ADDR_COMMAND;
    addr_tab[4] = 7'h38;

    // Reset values while reset is held
    #2;
    chk("rst_cyc_stb_we", {61'h0, cyc_o, stb_o, we_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_addr", 64'(addr_o), 64'd0);
    chk("rst_data", data_o, 64'd0);
    chk("rst_resp", {30'h0, resp_op_o, resp_data_o}, 64'd0);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_rst", 64'(req_ready_o), 64'd1);

    // Directed write / read-back / read with wide slave data
    slave_dly = 1; slave_rel = 1;
    txn(2'd2, DM_ADDR_DATA0, 32'hDEADBEEF, 0, 1'b0, "wr_data0");
    slave_dly = 0; slave_rel = 0;
    txn(2'd1, DM_ADDR_DATA0, 32'h0, 0, 1'b0, "rd_data0");
    chk("rd_data0_value", 64'(resp_data_o), 64'h0000_0000_DEAD_BEEF);
    slave_mem[32'h10] = 32'h9ABCDEF0;
    model_mem[32'h10] = 32'h9ABCDEF0;
    txn(2'd1, DM_ADDR_DMCONTROL, 32'h0, 0, 1'b0, "rd_dmcontrol");

    // Nop and reserved op: no bus cycle, response next cycle
    txn(2'd0, DM_ADDR_DATA1, 32'h1111_2222, 0, 1'b0, "nop");
    txn(2'd3, DM_ADDR_DATA1, 32'h3333_4444, 0, 1'b0, "op3");

    // Backpressure
    slave_dly = 2; slave_rel = 2;
    txn(2'd1, DM_ADDR_DATA1, 32'h0, 10, 1'b0, "backpressure");

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      slave_dly = $urandom_range(0, 3);
      slave_rel = $urandom_range(0, 3);
      rop = 2'($urandom_range(0, 3));
      ra  = addr_tab[$urandom_range(0, 4)];
      txn(rop, ra, $urandom(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
    end

`ifdef DMI_WB_TIMEOUT_EN
    // Unmapped slave never acks: bounded wait then failed status
    slave_mute = 1'b1;
    txn(2'd1, 7'h3F, 32'h0, 2, 1'b0, "timeout");
    slave_mute = 1'b0;
`endif

    // Reset in the middle of a stuck Wishbone cycle
    slave_mute  = 1'b1;
    req_valid_i = 1'b1;
    req_op_i    = 2'd1;
    req_addr_i  = 7'h3F;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    hi_cnt    = 0;
    resp_seen = 0;
`ifdef DMI_WB_TIMEOUT_EN
    for (int i = 0; i < TMO - 2; i++) begin
`else
    for (int i = 0; i < 100; i++) begin
`endif
      if (cyc_o) hi_cnt++;
      if (resp_valid_o) resp_seen++;
      @(posedge clk_i); #1;
    end
`ifdef DMI_WB_TIMEOUT_EN
    chk("stuck_cyc_high", 64'(hi_cnt), 64'(TMO - 2));
`else
    chk("stuck_cyc_high", 64'(hi_cnt), 64'd100);
`endif
    chk("stuck_no_resp", 64'(resp_seen), 64'd0);
    chk("stuck_cyc_now", 64'(cyc_o), 64'd1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("midrst_cyc_stb", {62'h0, cyc_o, stb_o}, 64'd0);
    chk("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("midrst_ready", 64'(req_ready_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i      = 1'b1;
    slave_mute = 1'b0;
    @(posedge clk_i); #1;
    chk("ready_after_midrst", 64'(req_ready_o), 64'd1);
    slave_dly = 1; slave_rel = 0;
    txn(2'd2, DM_ADDR_COMMAND, 32'h0022_1000, 0, 1'b0, "wr_command");
    txn(2'd1, DM_ADDR_COMMAND, 32'h0, 0, 1'b1, "rd_command");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
